mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
//  Two-port round-robin arbiter and sequencer for the shared memory bus (mem_cmd/mem_addr/write_data/read_data).
//  Sits between the CPU (port 0) and a second master such as a loader or debug port (port 1), upstream of RAM
//  and the memory-mapped IO decoder (LEDs at 9'h100, switches at 9'h140). Grants one transaction at a time.
//  Drives bus commands for exact cycle counts and returns read data with a valid pulse.
// PARAMETERS
//  AW      9   address width
//  DW      16  data width
//  RD_LAT  1   cycles mem_cmd=MREAD is held after the issue cycle before read_data is sampled; legal range 1..7
// PORTS
//  clk         in   1     system clock, all state on rising edge
//  reset       in   1     synchronous, active-high reset
//  req0_valid  in   1     port 0 request; cmd/addr/wdata held stable until req0_ready
//  req0_cmd    in   2     01=MREAD, 10=MWRITE, 11=MNONE, 00=reserved
//  req0_addr   in   AW    port 0 address
//  req0_wdata  in   DW    port 0 write data
//  req0_ready  out  1     one-cycle accept pulse (port 0)
//  req0_rvalid out  1     one-cycle read-data-valid pulse (port 0)
//  req1_*      --   --    same six signals for port 1
//  rdata       out  DW    read data captured from the bus, shared by both ports
//  mem_cmd     out  2     bus command, registered
//  mem_addr    out  AW    bus address, registered
//  write_data  out  DW    bus write data, registered
//  read_data   in   DW    bus read data (RAM or IO)
//  busy        out  1     high in every state except IDLE
// BEHAVIOUR
//  Reset values: mem_cmd=2'b11, mem_addr=0, write_data=0, rdata=0, all ready/rvalid=0, busy=0, state=IDLE, last_grant=1.
//  State machine:
//   IDLE    -> ISSUE if any valid. Latches the winner's cmd/addr/wdata into the bus registers.
//   ISSUE   -> 1 cycle. Drives the latched cmd and pulses the winner's ready.
//              Goes to WAIT_RD for a read, otherwise back to IDLE.
//   WAIT_RD -> RD_LAT cycles. mem_cmd stays MREAD and mem_addr stays stable.
//              On the last cycle, read_data is captured into rdata. -> IDLE.
//  Read return: the winner's rvalid pulses 1 cycle in the IDLE cycle after WAIT_RD.
//   rdata holds its value until the next read capture.
//  Arbitration:
//   - Only one valid: grant it.
//   - Both valid: grant the port != last_grant.
//   - last_grant updates on every grant.
//   - Reset priority therefore goes to port 0.
//  Latency, valid seen in IDLE at cycle T0:
//   - Write: bus write and ready in T1, IDLE in T2.
//   - Read: MREAD in T1..T1+RD_LAT, ready in T1, rvalid in T2+RD_LAT.
//  Next grant: the earliest new grant is evaluated in the IDLE cycle after the previous transaction.
//   Minimum spacing is 2 cycles per write and 2+RD_LAT cycles per read.
//  Bus cmd outside ISSUE/WAIT_RD is always MNONE (11).
//   MWRITE is asserted for exactly one cycle per accepted write, so the LED register loads once.
//  cmd 00 or 11 with valid: granted and ready pulsed; mem_cmd stays MNONE, no rvalid, arbitration pointer still updates.
//  Inputs are sampled only in IDLE; changes while not IDLE are ignored until ready is seen.
//  Deasserting valid before ready: request withdrawn, no bus activity.
//  Reset mid-operation (any state):
//   - Next cycle is IDLE with mem_cmd=MNONE.
//   - A pending read is discarded with no rvalid.
//   - ready/rvalid are 0.
//  The WAIT_RD counter is ceil(log2(RD_LAT+1)) bits, counts down from RD_LAT-1, and never wraps.
// TESTING
//  1 Hold reset 2 cycles -> mem_cmd=11, busy=0, all ready/rvalid=0, rdata=0.
//  2 req0 write addr 9'h100 wdata 16'h00A5 -> one cycle mem_cmd=10/addr 100/write_data 00A5 with req0_ready=1, then MNONE.
//  3 req1 read addr 9'h140, read_data=16'h0055, RD_LAT=1 -> MREAD for 2 cycles,
//    req1_rvalid=1 with rdata=0055 exactly 3 cycles after valid.
//  4 Both ports valid with back-to-back writes -> grants alternate 0,1,0,1; mem_addr follows; no port waits >1 transaction.
//  5 Reset asserted during WAIT_RD of a req0 read -> next cycle mem_cmd=11, busy=0; no req0_rvalid ever.
//  6 req0 valid cmd=00 addr 9'h100 -> req0_ready pulses, mem_cmd never leaves 11, LED register unchanged.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter and sequencer for the shared memory bus.
// Grants one transaction at a time and drives registered bus commands for fixed cycle counts.
module mem_bus_arbiter #(
  parameter int AW     = 9,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic [1:0]    req0_cmd,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_ready,
  output logic          req0_rvalid,
  input  logic          req1_valid,
  input  logic [1:0]    req1_cmd,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_ready,
  output logic          req1_rvalid,
  output logic [DW-1:0] rdata,
  output logic [1:0]    mem_cmd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] write_data,
  input  logic [DW-1:0] read_data,
  output logic          busy
);

  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;
  localparam logic [1:0] MNONE  = 2'b11;
  localparam int         CW     = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

  state_t          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      mem_cmd_q, mem_cmd_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   write_data_q, write_data_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            ready0_q, ready0_d, ready1_q, ready1_d;
  logic            rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic            busy_q, busy_d;
  logic            grant1;
  logic [1:0]      sel_cmd;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    mem_cmd_d    = mem_cmd_q;
    mem_addr_d   = mem_addr_q;
    write_data_d = write_data_q;
    rdata_d      = rdata_q;
    ready0_d     = 1'b0;
    ready1_d     = 1'b0;
    rvalid0_d    = 1'b0;
    rvalid1_d    = 1'b0;
    // On a tie the port that did not win last time gets the bus.
    grant1       = req1_valid && (!req0_valid || !last_grant_q);
    sel_cmd      = grant1 ? req1_cmd : req0_cmd;

    unique case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          state_d      = ISSUE;
          last_grant_d = grant1;
          mem_cmd_d    = (sel_cmd == MREAD || sel_cmd == MWRITE) ? sel_cmd : MNONE;
          mem_addr_d   = grant1 ? req1_addr : req0_addr;
          write_data_d = grant1 ? req1_wdata : req0_wdata;
          ready0_d     = !grant1;
          ready1_d     = grant1;
        end
      end
      ISSUE: begin
        if (mem_cmd_q == MREAD) begin
          state_d = WAIT_RD;
          cnt_d   = CW'(RD_LAT - 1);
        end else begin
          state_d   = IDLE;
          mem_cmd_d = MNONE;
        end
      end
      WAIT_RD: begin
        if (cnt_q == '0) begin
          state_d   = IDLE;
          mem_cmd_d = MNONE;
          rdata_d   = read_data;
          rvalid0_d = !last_grant_q;
          rvalid1_d = last_grant_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_cmd_d = MNONE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      mem_cmd_q    <= MNONE;
      mem_addr_q   <= '0;
      write_data_q <= '0;
      rdata_q      <= '0;
      ready0_q     <= 1'b0;
      ready1_q     <= 1'b0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      mem_cmd_q    <= mem_cmd_d;
      mem_addr_q   <= mem_addr_d;
      write_data_q <= write_data_d;
      rdata_q      <= rdata_d;
      ready0_q     <= ready0_d;
      ready1_q     <= ready1_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      busy_q       <= busy_d;
    end
  end

  assign req0_ready  = ready0_q;
  assign req1_ready  = ready1_q;
  assign req0_rvalid = rvalid0_q;
  assign req1_rvalid = rvalid1_q;
  assign rdata       = rdata_q;
  assign mem_cmd     = mem_cmd_q;
  assign mem_addr    = mem_addr_q;
  assign write_data  = write_data_q;
  assign busy        = busy_q;

endmodule
